// File: rtl/axi_time_pkg.sv
// axi_time_pkg: shared state encoding and constants for the time counter core.
package axi_time_pkg;
   typedef enum logic [1:0] {TIME_IDLE, TIME_WAIT_SYNC, TIME_RUNNING} time_state_t;
   localparam int TIME_SYNC_STAGES = 2;
endpackage

// File: rtl/axi_time_counter_if.sv
// axi_time_counter_if: overwrite/trigger handshakes and capture/event outputs of the time counter.
interface axi_time_counter_if #(parameter int COUNT_WIDTH = 64) ();
   logic [COUNT_WIDTH-1:0] time_overwrite;
   logic                   time_overwrite_valid;
   logic                   time_overwrite_ready;
   logic [COUNT_WIDTH-1:0] time_rx_trigger;
   logic                   time_rx_trigger_valid;
   logic                   time_rx_trigger_ready;
   logic [COUNT_WIDTH-1:0] time_rx_capture;
   logic                   time_rx_capture_valid;
   logic                   time_rx_event;
   logic                   time_underrun;
   modport master (
      output time_overwrite, time_overwrite_valid, time_rx_trigger, time_rx_trigger_valid,
      input  time_overwrite_ready, time_rx_trigger_ready, time_rx_capture, time_rx_capture_valid,
             time_rx_event, time_underrun
   );
   modport slave (
      input  time_overwrite, time_overwrite_valid, time_rx_trigger, time_rx_trigger_valid,
      output time_overwrite_ready, time_rx_trigger_ready, time_rx_capture, time_rx_capture_valid,
             time_rx_event, time_underrun
   );
endinterface

// File: rtl/axi_time_sync_edge.sv
// axi_time_sync_edge: optional SYNC_STAGES-flop synchronizer followed by a rising-edge pulse.
module axi_time_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);
   logic s, prev;
   if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sq;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sq <= '0;
         else begin
            sq[0] <= d;
            for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
         end
      end
      assign s = sq[SYNC_STAGES-1];
   end else begin : g_direct
      assign s = d;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= 1'b0;
      else prev <= s;
   end
   assign pulse = s & ~prev;
endmodule

// File: rtl/axi_time_counter.sv
// axi_time_counter: free-running timebase with sync start, overwrite and RX trigger matching.
// Optional external capture input enabled by defining AXI_TIME_CAPTURE_EXT_EN.
module axi_time_counter
   import axi_time_pkg::*;
#(
   parameter int COUNT_WIDTH       = 64,
   parameter int SYNC_EXTERNAL     = 0,
   parameter int SYNC_EXTERNAL_CDC = 0
) (
   input  logic                   time_clk,
   input  logic                   time_resetn,
   input  logic                   time_enable,
   input  logic                   time_sync_ext,
   input  logic                   time_sync_soft,
   input  logic                   time_sync_in,
`ifdef AXI_TIME_CAPTURE_EXT_EN
   input  logic                   time_capture_ext,
`endif
   axi_time_counter_if.slave      bus,
   output logic [COUNT_WIDTH-1:0] time_counter,
   output logic                   time_running
);
   time_state_t state, state_nx;
   logic [COUNT_WIDTH-1:0] cnt, cnt_nx, trig, capture;
   logic pending, ow_ready, ow_hs, tr_hs, ext_en, sync_evt, sync_pulse, cap_pulse;
   logic hit, miss, cap, running, rx_event, cap_valid, underrun;
   axi_time_sync_edge #(.SYNC_STAGES(SYNC_EXTERNAL_CDC != 0 ? TIME_SYNC_STAGES : 0)) u_sync_in (
      .clk(time_clk), .rst_n(time_resetn), .d(time_sync_in), .pulse(sync_pulse)
   );
`ifdef AXI_TIME_CAPTURE_EXT_EN
   axi_time_sync_edge #(.SYNC_STAGES(TIME_SYNC_STAGES)) u_cap_ext (
      .clk(time_clk), .rst_n(time_resetn), .d(time_capture_ext), .pulse(cap_pulse)
   );
`else
   assign cap_pulse = 1'b0;
`endif
   assign ext_en   = time_sync_ext & (SYNC_EXTERNAL != 0);
   assign sync_evt = time_sync_soft | (sync_pulse & (SYNC_EXTERNAL != 0));
   assign ow_hs    = bus.time_overwrite_valid & ow_ready;
   assign tr_hs    = bus.time_rx_trigger_valid & ~pending;
   always_ff @(posedge time_clk or negedge time_resetn) begin
      if (!time_resetn) state <= TIME_IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (!time_enable) state_nx = TIME_IDLE;
      else if (state == TIME_IDLE) state_nx = ext_en ? TIME_WAIT_SYNC : TIME_RUNNING;
      else if (state == TIME_WAIT_SYNC && sync_evt) state_nx = TIME_RUNNING;
   end
   // Overwrite wins over both increment and the sync clear.
   always_comb begin
      hit    = state == TIME_RUNNING && pending && cnt == trig;
      miss   = state == TIME_RUNNING && pending && cnt > trig;
      cap    = hit | cap_pulse;
      cnt_nx = ow_hs ? bus.time_overwrite :
               (state == TIME_RUNNING && time_enable) ? cnt + COUNT_WIDTH'(1) :
               (state == TIME_WAIT_SYNC && time_enable && sync_evt) ? '0 : cnt;
   end
   always_ff @(posedge time_clk or negedge time_resetn) begin
      if (!time_resetn) begin
         cnt       <= '0;
         trig      <= '0;
         capture   <= '0;
         pending   <= 1'b0;
         ow_ready  <= 1'b0;
         running   <= 1'b0;
         rx_event  <= 1'b0;
         cap_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         cnt       <= cnt_nx;
         pending   <= tr_hs | (pending & ~(hit | miss));
         ow_ready  <= 1'b1;
         running   <= state_nx == TIME_RUNNING;
         rx_event  <= hit;
         cap_valid <= cap;
         underrun  <= miss;
         if (tr_hs) trig <= bus.time_rx_trigger;
         if (cap) capture <= cnt;
      end
   end
   assign time_counter              = cnt;
   assign time_running              = running;
   assign bus.time_overwrite_ready  = ow_ready;
   assign bus.time_rx_trigger_ready = ~pending;
   assign bus.time_rx_capture       = capture;
   assign bus.time_rx_capture_valid = cap_valid;
   assign bus.time_rx_event         = rx_event;
   assign bus.time_underrun         = underrun;
endmodule
